// File: rtl/spi_slave_core_if.sv
// spi_slave_core_if: word-level handshake and status signals between the SPI slave core and its host
interface spi_slave_core_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;
  logic              underrun;
  logic              frame_err;
  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid, busy, underrun, frame_err
  );
  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid, busy, underrun, frame_err
  );
endinterface

// File: rtl/spi_slave_core.sv
// spi_slave_core: oversampled SPI slave with all CPOL/CPHA modes, full duplex and gapless multi-word frames
module spi_slave_core #(
  parameter int                DATA_W    = 8,
  parameter bit                CPOL      = 1'b0,
  parameter bit                CPHA      = 1'b0,
  parameter bit                MSB_FIRST = 1'b1,
  parameter logic [DATA_W-1:0] IDLE_WORD = '0
) (
  input  logic            clk,
  input  logic            n_rst,
  spi_slave_core_if.slave bus,
  input  logic            sclk,
  input  logic            cs_n,
  input  logic            mosi,
  output logic            miso,
  output logic            miso_oe
);
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  state_t state, state_nx;
  logic [2:0] sclk_s, cs_s;
  logic [1:0] mosi_s;
  logic [DATA_W-1:0] hold, tx_sh, rx_sh, rx_nx, rx_data_q;
  logic [CNT_W-1:0] bit_cnt;
  logic hold_full, fresh, ur_pend, rx_valid_q, underrun_q, frame_err_q;
  logic lead, trail, samp, shft, cs_fall, cs_rise;
  logic do_end, do_load, do_shift, do_samp;
  assign lead    = (sclk_s[1] != CPOL) && (sclk_s[2] == CPOL);
  assign trail   = (sclk_s[1] == CPOL) && (sclk_s[2] != CPOL);
  assign samp    = CPHA ? trail : lead;
  assign shft    = CPHA ? lead : trail;
  assign cs_fall = !cs_s[1] && cs_s[2];
  assign cs_rise = cs_s[1] && !cs_s[2];
  assign rx_nx   = MSB_FIRST ? {rx_sh[DATA_W-2:0], mosi_s[1]} : {mosi_s[1], rx_sh[DATA_W-1:1]};
  assign miso_oe = state == SHIFT;
  assign miso    = miso_oe && (MSB_FIRST ? tx_sh[DATA_W-1] : tx_sh[0]);
  assign bus.tx_ready  = !hold_full;
  assign bus.busy      = state != IDLE;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.underrun  = underrun_q;
  assign bus.frame_err = frame_err_q;
  // Synchronisers plus history stage; cs resets low so a CS already asserted at release is not taken as a fresh fall
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      sclk_s <= {3{CPOL}};
      cs_s   <= '0;
      mosi_s <= '0;
    end else begin
      sclk_s <= {sclk_s[1:0], sclk};
      cs_s   <= {cs_s[1:0], cs_n};
      mosi_s <= {mosi_s[0], mosi};
    end
  // State register
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) state <= IDLE;
    else        state <= state_nx;
  // Next state and datapath strobes; a CS rise wins over any SCLK edge in the same cycle
  always_comb begin
    do_end   = state != IDLE && cs_rise;
    do_load  = !do_end && (state == LOAD || (state == SHIFT && shft && bit_cnt == '0 && !fresh));
    do_shift = !do_end && state == SHIFT && shft && bit_cnt != '0;
    do_samp  = !do_end && state == SHIFT && samp;
    state_nx = do_end ? IDLE : state == IDLE ? (cs_fall ? LOAD : IDLE) : SHIFT;
  end
  // Shift registers, holding register and status pulses; an inline reload that underruns is only
  // reported once its first bit is sampled, so the preload after a frame's last word stays silent
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      hold        <= '0;
      tx_sh       <= '0;
      rx_sh       <= '0;
      rx_data_q   <= '0;
      bit_cnt     <= '0;
      hold_full   <= 1'b0;
      fresh       <= 1'b0;
      ur_pend     <= 1'b0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
      if (do_load) begin
        tx_sh      <= hold_full ? hold : IDLE_WORD;
        hold_full  <= 1'b0;
        fresh      <= 1'b1;
        underrun_q <= state == LOAD && !hold_full;
        ur_pend    <= state == SHIFT && !hold_full;
      end
      if (do_shift) tx_sh <= MSB_FIRST ? tx_sh << 1 : tx_sh >> 1;
      if (do_samp) begin
        rx_sh      <= rx_nx;
        fresh      <= 1'b0;
        ur_pend    <= 1'b0;
        underrun_q <= ur_pend;
        bit_cnt    <= bit_cnt == LAST ? '0 : bit_cnt + 1'b1;
        rx_valid_q <= bit_cnt == LAST;
        if (bit_cnt == LAST) rx_data_q <= rx_nx;
      end
      if (do_end) begin
        frame_err_q <= bit_cnt != '0;
        bit_cnt     <= '0;
        ur_pend     <= 1'b0;
      end
      if (bus.tx_valid && !hold_full) begin
        hold      <= bus.tx_data;
        hold_full <= 1'b1;
      end
    end
endmodule

// File: tb/tb_spi_slave_core.sv
// tb_spi_slave_core: directed bench over all SPI modes, bit orders, multi-word, underrun, frame error and a shared MISO pair
module tb_spi_slave_core;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic ph = 1'b0;
  logic mosi = 1'b0;
  logic [6:0] cs = '1;
  logic [6:0] tx_valid = '0;
  logic [6:0] tx_ready, rx_valid, busy, underrun, frame_err, miso_k, oe;
  logic [15:0] tx_data [7];
  logic [15:0] rx_data [7];
  logic miso_bus;
  logic [15:0] r;
  int n_cmp = 0;
  int n_err = 0;
  int n_rv [7];
  int n_ur [7];
  int n_fe [7];
  int s_rv, s_ur, s_fe;
  always #5 clk = ~clk;
  // k 0..3: 16-bit modes 0..3; k 4: 16-bit mode 0 LSB first; k 5,6: 8-bit mode 0 sharing MISO
  for (genvar k = 0; k < 7; k++) begin : g
    localparam int W = k < 5 ? 16 : 8;
    spi_slave_core_if #(.DATA_W(W)) b ();
    assign b.tx_data    = tx_data[k][W-1:0];
    assign b.tx_valid   = tx_valid[k];
    assign tx_ready[k]  = b.tx_ready;
    assign rx_valid[k]  = b.rx_valid;
    assign busy[k]      = b.busy;
    assign underrun[k]  = b.underrun;
    assign frame_err[k] = b.frame_err;
    assign rx_data[k]   = 16'(b.rx_data);
    spi_slave_core #(
      .DATA_W(W), .CPOL(k == 2 || k == 3), .CPHA(k == 1 || k == 3), .MSB_FIRST(k != 4)
    ) u (
      .clk(clk), .n_rst(n_rst), .bus(b), .sclk(ph ^ (k == 2 || k == 3)), .cs_n(cs[k]),
      .mosi(mosi), .miso(miso_k[k]), .miso_oe(oe[k])
    );
  end
  assign miso_bus = oe[5] ? miso_k[5] : oe[6] ? miso_k[6] : 1'b0;
  always @(posedge clk)
    for (int i = 0; i < 7; i++) begin
      n_rv[i] += int'(rx_valid[i]);
      n_ur[i] += int'(underrun[i]);
      n_fe[i] += int'(frame_err[i]);
    end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [6:0] st(input int k);
    return {miso_k[k], oe[k], tx_ready[k], rx_valid[k], busy[k], underrun[k], frame_err[k]};
  endfunction
  task automatic snap(input int k);
    s_rv = n_rv[k];
    s_ur = n_ur[k];
    s_fe = n_fe[k];
  endtask
  task automatic push(input int k, input logic [15:0] d);
    int t = 0;
    while (!tx_ready[k] && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("tx_ready%0d", k), 32'(tx_ready[k]), 1);
    @(negedge clk);
    tx_data[k]  = d;
    tx_valid[k] = 1'b1;
    @(negedge clk);
    tx_valid[k] = 1'b0;
  endtask
  // Bit-banged master: 8 clk per SCLK period, captures MISO MSB-first on the wire
  task automatic xfer(input int k, input int nb, input logic [15:0] mo, output logic [15:0] mi);
    logic cpha;
    cpha = k == 1 || k == 3;
    mi = '0;
    @(negedge clk);
    cs[k] = 1'b0;
    #80;
    for (int i = nb - 1; i >= 0; i--) begin
      if (cpha) begin
        ph = 1'b1;
        mosi = mo[i];
        #40;
        mi = {mi[14:0], k >= 5 ? miso_bus : miso_k[k]};
        ph = 1'b0;
        #40;
      end else begin
        mosi = mo[i];
        #40;
        mi = {mi[14:0], k >= 5 ? miso_bus : miso_k[k]};
        ph = 1'b1;
        #40;
        ph = 1'b0;
      end
    end
    #40;
    cs[k] = 1'b1;
    #80;
  endtask
  initial begin
    for (int i = 0; i < 7; i++) tx_data[i] = '0;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("reset_flags%0d", i), st(i), 7'b0010000);
      chk($sformatf("reset_rx%0d", i), rx_data[i], 0);
    end
    push(5, 16'h00C5);
    snap(5);
    xfer(5, 8, 16'h003A, r);
    chk("m0_miso", r, 16'h00C5);
    chk("m0_rx", rx_data[5], 16'h003A);
    chk("m0_rv", n_rv[5] - s_rv, 1);
    chk("m0_fe", n_fe[5] - s_fe, 0);
    for (int k = 0; k < 5; k++) begin
      push(k, 16'hA55A);
      snap(k);
      xfer(k, 16, k == 4 ? 16'h2C48 : 16'h1234, r);
      chk($sformatf("mode%0d_miso", k), r, k == 4 ? 16'h5AA5 : 16'hA55A);
      chk($sformatf("mode%0d_rx", k), rx_data[k], 16'h1234);
      chk($sformatf("mode%0d_rv", k), n_rv[k] - s_rv, 1);
      chk($sformatf("mode%0d_ur", k), n_ur[k] - s_ur, 0);
    end
    push(5, 16'h00C6);
    snap(5);
    fork
      xfer(5, 16, 16'h5A96, r);
      push(5, 16'h00C7);
    join
    chk("2w_miso", r, 16'hC6C7);
    chk("2w_rx", rx_data[5], 16'h0096);
    chk("2w_rv", n_rv[5] - s_rv, 2);
    chk("2w_ur", n_ur[5] - s_ur, 0);
    snap(5);
    xfer(5, 8, 16'h00FF, r);
    chk("ur_miso", r, 16'h0000);
    chk("ur_pulse", n_ur[5] - s_ur, 1);
    chk("ur_rx", rx_data[5], 16'h00FF);
    push(5, 16'h00C8);
    snap(5);
    xfer(5, 5, 16'h0015, r);
    chk("fe_miso", r, 16'h0019);
    chk("fe_pulse", n_fe[5] - s_fe, 1);
    chk("fe_rv", n_rv[5] - s_rv, 0);
    chk("fe_oe", 32'(oe[5]), 0);
    chk("fe_rx_held", rx_data[5], 16'h00FF);
    push(5, 16'h0081);
    snap(5);
    xfer(5, 8, 16'h007E, r);
    chk("post_fe_miso", r, 16'h0081);
    chk("post_fe_rx", rx_data[5], 16'h007E);
    chk("post_fe_fe", n_fe[5] - s_fe, 0);
    push(5, 16'h00C5);
    push(6, 16'h00C6);
    xfer(5, 8, 16'h0011, r);
    chk("sh5_miso", r, 16'h00C5);
    xfer(6, 8, 16'h0022, r);
    chk("sh6_miso", r, 16'h00C6);
    chk("sh6_rx", rx_data[6], 16'h0022);
    push(5, 16'h00C7);
    push(6, 16'h00C8);
    fork
      xfer(5, 8, 16'h0033, r);
      begin
        @(negedge clk);
        #200;
        chk("sh_oe_sel", {oe[6], oe[5]}, 2'b01);
        #100;
        n_rst = 1'b0;
        #2;
        chk("rst_async", {oe[5], busy[5]}, 2'b00);
        #18;
        n_rst = 1'b1;
        #40;
        for (int k = 5; k < 7; k++) begin
          chk($sformatf("rst_flags%0d", k), st(k), 7'b0010000);
          chk($sformatf("rst_rx%0d", k), rx_data[k], 0);
        end
      end
    join
    chk("rst_no_resume", 32'(busy[5]), 0);
    push(6, 16'h00C8);
    snap(6);
    xfer(6, 8, 16'h0055, r);
    chk("clean_miso", r, 16'h00C8);
    chk("clean_rx", rx_data[6], 16'h0055);
    chk("clean_rv", n_rv[6] - s_rv, 1);
    chk("clean_fe", n_fe[6] - s_fe, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/spi_slave_core.md
# spi_slave_core

Parametrised SPI slave, successor to the fixed 8-bit, mode-0, transmit-only ADC slave model. Runs entirely in the system clock domain: SCLK, CS_N and MOSI are oversampled and synchronised. The core supports configurable word width, all four CPOL/CPHA modes, selectable bit order, full-duplex receive, multi-word frames and a tristate-enable MISO, so several slaves can share one MISO line.

## Interface
- DATA_W, 8: word width in bits, 2..32
- CPOL, 0: SCLK idle level
- CPHA, 0: 0 = sample on leading edge, shift on trailing edge; 1 = shift on leading edge, sample on trailing edge
- MSB_FIRST, 1: 1 = MSB first on both MISO and MOSI; 0 = LSB first
- IDLE_WORD, 0: word shifted out on underrun

Ports:
- clk  in  1  system clock; must run at ≥ 8× SCLK
- n_rst  in  1  reset, asynchronous, active-low
- tx_data  in  DATA_W  next word to transmit
- tx_valid  in  1  tx_data is valid
- tx_ready  out  1  holding register empty; a transfer occurs when tx_valid && tx_ready
- rx_data  out  DATA_W  last received word; held until the next word completes
- rx_valid  out  1  one-cycle pulse when rx_data updates
- sclk  in  1  SPI clock (asynchronous)
- cs_n  in  1  chip select, active-low (asynchronous)
- mosi  in  1  master-out data (asynchronous)
- miso  out  1  slave-out data
- miso_oe  out  1  MISO drive enable; the top level tristates MISO when low
- busy  out  1  chip select is asserted (synchronised)
- underrun  out  1  one-cycle pulse: a word was loaded from an empty holding register
- frame_err  out  1  one-cycle pulse: CS deasserted mid-word

## Operation
- Synchronisers: 2-FF on sclk, cs_n and mosi, plus one history FF on sclk and cs_n for edge detection. Leading edge = SCLK leaving the CPOL level; trailing edge = SCLK returning to it.
- Holding register: loaded when tx_valid && tx_ready, after which tx_ready goes low. It is emptied, and tx_ready goes high the next cycle, when its word is moved into the shift register.
- States:
  - IDLE: miso_oe=0, bit_cnt=0. A synchronised CS fall moves to LOAD.
  - LOAD, one cycle: shift register ← holding register, or IDLE_WORD with an underrun pulse if the holding register is empty. MISO presents the first bit, miso_oe=1. Go to SHIFT.
  - SHIFT, on each sample edge:
    - Capture mosi into the rx shift register and increment bit_cnt.
    - When bit_cnt reaches DATA_W: rx_data ← assembled word, rx_valid pulse, bit_cnt ← 0.
  - SHIFT, on each shift edge: advance the MISO bit.
    - On the shift edge that follows word completion, perform the LOAD action inline so the next word's first bit is driven. This gives multi-word frames with no gap.
    - CPHA=1: the first leading edge shifts nothing new, because the first bit was already driven in LOAD.
  - SHIFT, on a synchronised CS rise: if bit_cnt≠0, pulse frame_err and discard the partial word (no rx_valid). Go to IDLE; miso_oe=0 on the same cycle.
- CS rise takes priority over an SCLK edge detected in the same cycle.
- SCLK edges while CS is deasserted are ignored.
- An unconsumed rx_data word is overwritten by the next completed word; there is no rx backpressure.

## Timing
- Reset values:
  - miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, underrun=0, frame_err=0.
  - State=IDLE, bit_cnt=0, holding register empty.
- n_rst low at any time, including mid-frame, forces the reset values immediately. After release the core waits in IDLE for a fresh CS fall; it does not resume a frame whose CS is already low.
- Pin-to-detect latency: 3 clk cycles for SCLK/CS edges.
- MISO updates ≤ 4 clk after the pin shift edge.
- First bit is valid ≤ 5 clk after the CS fall pin edge; the master must allow ≥ 5 clk before the first leading edge.
- rx_valid is asserted 1 clk after the internal sample edge that completes the word.
- tx_ready rises 1 clk after the word is moved to the shift register.

## Test plan
- Mode 0, DATA_W=8, tx 0xC5, master sends 0x3A with 8 SCLKs → MISO bits 1,1,0,0,0,1,0,1; rx_data=0x3A with one rx_valid; no frame_err.
- All 4 CPOL/CPHA modes, DATA_W=16, tx 0xA55A, MOSI 0x1234 → master reads 0xA55A; rx_data=0x1234 in every mode; MSB_FIRST=0 run yields bit-reversed wire order.
- Two-word frame: queue 0xC6, then 0xC7 after tx_ready rises; 16 SCLKs under one CS → MISO 0xC6 then 0xC7 contiguously; two rx_valid pulses; no underrun.
- Underrun: CS asserted with no tx_valid → MISO shifts IDLE_WORD=0x00; underrun pulses once.
- CS deasserted after 5 of 8 bits → frame_err pulse; no rx_valid; miso_oe low; next full frame is correct.
- Two instances share MISO, CS alternating as 0xC5..0xC8 are loaded; n_rst pulsed mid-frame → only the selected instance has miso_oe=1; after reset all outputs are at reset values and the next frame is clean.
